axi_mst: RTL and testbench
==========================

Name: axi_mst

Overview:
- Single-outstanding AXI initiator. It converts one command per transaction (read or write, INCR burst of 1-16 beats) into AXI AR/R or AW/W/B traffic.
- It is the requesting end for axi_slv-style responders on the DMA path.
- Read data streams out, and write data streams in, over simple valid/ready ports.
- Completion is reported with a one-cycle done pulse carrying an error flag.

Parameters:
- AW, 32, address width.
- DW, 32, data width; must be a power of two, 8 or greater.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when valid&ready.
- cmd_write  in  1  1=write, 0=read.
- cmd_addr  in  AW  start address, size-aligned.
- cmd_len  in  4  beats-1.
- wd_valid  in  1  write data beat available.
- wd_ready  out  1  write data beat consumed.
- wd_data  in  DW  write data.
- wd_strb  in  DW/8  byte strobes.
- rd_valid  out  1  read data beat valid.
- rd_ready  in  1  read data beat consumed.
- rd_data  out  DW  read data.
- rd_last  out  1  final beat of the read burst.
- done  out  1  one-cycle pulse at transaction end.
- done_err  out  1  valid with done; 1 if any resp was non-OKAY or the rlast count mismatched.
- AXI master side: all axi_slv signals with opposite direction.
  - AR: arvalid, arready, araddr, arcache, arprot, arburst, arlen, arsize.
  - AW: awvalid, awready, awaddr, awcache, awprot, awburst, awlen, awsize.
  - R: rvalid, rready, rdata, rresp, rlast.
  - W: wvalid, wready, wdata, wstrb, wlast.
  - B: bvalid, bready, bresp.

Behaviour:
- States: IDLE, AR, R, AW, W, B, DONE. Reset to IDLE.
- Reset values: all valid/ready/done outputs are 0; counters, done_err and error flag are 0.
- Reset is asynchronous. Reset mid-burst aborts immediately and returns to IDLE with no done pulse. The slave must be reset together with this block.
- IDLE:
  - cmd_ready=1 only in IDLE.
  - On cmd_valid, latch addr/len/write, clear beat counter and error flag.
  - Go to AR (read) or AW (write).
- AR / AW:
  - arvalid/awvalid is registered: high from the cycle after acceptance until the arready/awready handshake.
  - addr, len and attributes are held stable while valid.
  - arlen/awlen=latched len; arsize/awsize=log2(DW/8); arburst/awburst=2'b01; cache=4'b0000; prot=3'b000.
  - On handshake go to R / W.
- R:
  - Pass-through, combinational: rready=rd_ready, rd_valid=rvalid, rd_data=rdata.
  - rd_last=1 when beat counter==len (counted, not taken from rlast).
  - On each rvalid&rready: counter increments; error flag |= (rresp!=0).
  - On the counted final beat: error flag |= (rlast==0); go to DONE.
  - A beat with rlast=1 before the final count: error flag set, counting continues.
- W:
  - Pass-through: wvalid=wd_valid, wd_ready=wready, wdata=wd_data, wstrb=wd_strb.
  - wlast=1 when beat counter==len.
  - The counter increments on each wvalid&wready.
  - After the handshake with wlast=1, go to B.
  - W is entered only after AW completes.
- B:
  - bready=1.
  - On bvalid, error flag |= (bresp!=0); go to DONE.
- DONE:
  - done=1 and done_err=error flag for exactly one cycle; then IDLE.
  - cmd_ready returns high the cycle after done.
- Outside R/W, all pass-through valid/ready outputs are forced to 0. Data outputs are don't-care but driven to 0.
- Counter is 4 bits. len=15 gives 16 beats with no wrap; len=0 is a single beat with last asserted on it.
- Minimum latency:
  - Read: cmd accept → arvalid at +1; 1-beat read done at +3 with zero-wait slave.
  - Write: 1-beat write done at +4 (AW, W, B, DONE).
- Stalls (arready/wready/rvalid/bvalid low) hold state indefinitely; there is no timeout.

Test Plan:
- Read, addr=0x1000, len=3, zero-wait slave returning data 0..3 with rlast on beat 3.
  - arvalid at cycle+1 with arlen=3, arsize=2 (DW=32).
  - 4 rd beats, rd_last on the 4th.
  - done at the expected cycle with done_err=0.
- Write, addr=0x2000, len=1, wd_data 0xA5A5A5A5/0x5A5A5A5A, strb=4'hF, wready toggling every other cycle.
  - wlast only on the 2nd beat; bready=1 in B.
  - done with done_err=0; cmd_ready low throughout.
- Read with rresp=2'b10 on beat 0, len=0 → done_err=1.
- Write with bresp=2'b11 → done_err=1.
- Read, len=2, slave asserts rlast early on beat 1 → 3 beats still taken, done_err=1.
- Reset mid-burst:
  - Assert rst_n=0 during beat 5 of a len=15 read; all outputs 0 asynchronously; no done.
  - After release, a new len=15 read completes all 16 beats with done_err=0.
- Backpressure: rd_ready held low 10 cycles mid-burst → rready low, no beat lost, counter unchanged.

Source files
------------

// File: rtl/axi_mst.sv
// Single-outstanding AXI initiator: one command becomes one INCR burst (AR/R or AW/W/B),
// with read/write data streamed over valid/ready ports and a one-cycle done pulse.
module axi_mst #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  // command
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_write,
  input  logic [AW-1:0]   cmd_addr,
  input  logic [3:0]      cmd_len,
  // write data stream
  input  logic            wd_valid,
  output logic            wd_ready,
  input  logic [DW-1:0]   wd_data,
  input  logic [DW/8-1:0] wd_strb,
  // read data stream
  output logic            rd_valid,
  input  logic            rd_ready,
  output logic [DW-1:0]   rd_data,
  output logic            rd_last,
  // completion
  output logic            done,
  output logic            done_err,
  // AXI read address
  output logic            arvalid,
  input  logic            arready,
  output logic [AW-1:0]   araddr,
  output logic [3:0]      arcache,
  output logic [2:0]      arprot,
  output logic [1:0]      arburst,
  output logic [7:0]      arlen,
  output logic [2:0]      arsize,
  // AXI write address
  output logic            awvalid,
  input  logic            awready,
  output logic [AW-1:0]   awaddr,
  output logic [3:0]      awcache,
  output logic [2:0]      awprot,
  output logic [1:0]      awburst,
  output logic [7:0]      awlen,
  output logic [2:0]      awsize,
  // AXI read data
  input  logic            rvalid,
  output logic            rready,
  input  logic [DW-1:0]   rdata,
  input  logic [1:0]      rresp,
  input  logic            rlast,
  // AXI write data
  output logic            wvalid,
  input  logic            wready,
  output logic [DW-1:0]   wdata,
  output logic [DW/8-1:0] wstrb,
  output logic            wlast,
  // AXI write response
  input  logic            bvalid,
  output logic            bready,
  input  logic [1:0]      bresp
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_AR   = 3'd1;
  localparam logic [2:0] ST_R    = 3'd2;
  localparam logic [2:0] ST_AW   = 3'd3;
  localparam logic [2:0] ST_W    = 3'd4;
  localparam logic [2:0] ST_B    = 3'd5;
  localparam logic [2:0] ST_DONE = 3'd6;

  localparam logic [2:0] SIZE = 3'($clog2(DW / 8));

  logic [2:0]    state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [3:0]    len_q, len_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          cmd_ready_q;
  logic          last_beat;
  logic          in_r, in_w;

  assign last_beat = (cnt_q == len_q);
  assign in_r      = (state_q == ST_R);
  assign in_w      = (state_q == ST_W);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          addr_d  = cmd_addr;
          len_d   = cmd_len;
          cnt_d   = 4'd0;
          err_d   = 1'b0;
          state_d = cmd_write ? ST_AW : ST_AR;
        end
      end
      ST_AR: if (arready) state_d = ST_R;
      ST_R: begin
        if (rvalid && rd_ready) begin
          cnt_d = cnt_q + 4'd1;
          if (rresp != 2'b00) err_d = 1'b1;
          // Burst end is counted locally; rlast only cross-checks the slave.
          if (last_beat) begin
            if (!rlast) err_d = 1'b1;
            state_d = ST_DONE;
          end else if (rlast) begin
            err_d = 1'b1;
          end
        end
      end
      ST_AW: if (awready) state_d = ST_W;
      ST_W: begin
        if (wd_valid && wready) begin
          cnt_d = cnt_q + 4'd1;
          if (last_beat) state_d = ST_B;
        end
      end
      ST_B: begin
        if (bvalid) begin
          if (bresp != 2'b00) err_d = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      len_q       <= 4'd0;
      cnt_q       <= 4'd0;
      err_q       <= 1'b0;
      cmd_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      // Registered so cmd_ready stays low while reset is asserted.
      cmd_ready_q <= (state_d == ST_IDLE);
    end
  end

  assign cmd_ready = cmd_ready_q;

  assign arvalid = (state_q == ST_AR);
  assign araddr  = addr_q;
  assign arlen   = {4'd0, len_q};
  assign arsize  = SIZE;
  assign arburst = 2'b01;
  assign arcache = 4'b0000;
  assign arprot  = 3'b000;

  assign awvalid = (state_q == ST_AW);
  assign awaddr  = addr_q;
  assign awlen   = {4'd0, len_q};
  assign awsize  = SIZE;
  assign awburst = 2'b01;
  assign awcache = 4'b0000;
  assign awprot  = 3'b000;

  assign rready   = in_r & rd_ready;
  assign rd_valid = in_r & rvalid;
  assign rd_data  = in_r ? rdata : '0;
  assign rd_last  = in_r & last_beat;

  assign wvalid   = in_w & wd_valid;
  assign wd_ready = in_w & wready;
  assign wdata    = in_w ? wd_data : '0;
  assign wstrb    = in_w ? wd_strb : '0;
  assign wlast    = in_w & last_beat;

  assign bready   = (state_q == ST_B);
  assign done     = (state_q == ST_DONE);
  assign done_err = done & err_q;

endmodule

// File: tb/tb_axi_mst.sv
// Randomized bench for axi_mst: a transaction-level slave/consumer model predicts every
// handshake, data beat and completion status and checks the DUT cycle by cycle.
module tb_axi_mst;

  logic        clk, rst_n;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr;
  logic [3:0]  cmd_len;
  logic        wd_valid, wd_ready;
  logic [31:0] wd_data;
  logic [3:0]  wd_strb;
  logic        rd_valid, rd_ready, rd_last;
  logic [31:0] rd_data;
  logic        done, done_err;
  logic        arvalid, arready, awvalid, awready;
  logic [31:0] araddr, awaddr;
  logic [3:0]  arcache, awcache;
  logic [2:0]  arprot, awprot, arsize, awsize;
  logic [1:0]  arburst, awburst;
  logic [7:0]  arlen, awlen;
  logic        rvalid, rready, rlast;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        wvalid, wready, wlast;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        bvalid, bready;
  logic [1:0]  bresp;

  axi_mst #(.AW(32), .DW(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data), .wd_strb(wd_strb),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .done(done), .done_err(done_err),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arcache(arcache),
    .arprot(arprot), .arburst(arburst), .arlen(arlen), .arsize(arsize),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awcache(awcache),
    .awprot(awprot), .awburst(awburst), .awlen(awlen), .awsize(awsize),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bresp(bresp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Per-beat behaviour of the slave and data source for the next transaction.
  logic [31:0] rdat_tab [16];
  logic [1:0]  rresp_tab[16];
  logic        rlast_tab[16];
  logic [31:0] wdat_tab [16];
  logic [3:0]  wstrb_tab[16];
  logic [1:0]  bresp_val;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    wd_valid = 1'b0; wd_data = '0; wd_strb = '0; rd_ready = 1'b0;
    arready = 1'b0; awready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = '0; rlast = 1'b0;
    wready = 1'b0; bvalid = 1'b0; bresp = '0;
  endtask

  task automatic set_clean(input logic [3:0] len);
    for (int i = 0; i < 16; i++) begin
      rdat_tab[i]  = $urandom;
      rresp_tab[i] = 2'b00;
      rlast_tab[i] = (i == int'(len));
      wdat_tab[i]  = $urandom;
      wstrb_tab[i] = 4'($urandom);
    end
    bresp_val = 2'b00;
  endtask

  // mode: 0 zero-wait, 1 random stalls, 2 wready toggling, 3 rd_ready held low 10 cycles.
  // abort_at >= 0 pulls reset while read beat abort_at is on the bus.
  task automatic run_txn(input bit wr, input logic [31:0] addr, input logic [3:0] len,
                         input int mode, input int abort_at, output int done_cyc);
    bit ar_done = 0, aw_done = 0, r_fin = 0, w_fin = 0, b_done = 0, done_due = 0;
    bit exp_err = 0;
    int rb = 0, wb = 0, hold = 0, cyc;
    int n_beats = int'(len) + 1;
    done_cyc = -1;
    if (wr) exp_err = (bresp_val != 2'b00);
    else
      for (int i = 0; i < n_beats; i++)
        if (rresp_tab[i] != 2'b00 || rlast_tab[i] != (i == int'(len))) exp_err = 1;

    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_len = len;
    #1 check_eq("cmd_ready_idle", 64'(cmd_ready), 64'd1);
    @(negedge clk);
    cmd_valid = 1'b0; cmd_write = 1'($urandom); cmd_addr = $urandom; cmd_len = 4'($urandom);
    cyc = 1;
    while (done_cyc < 0 && cyc < 400) begin
      bit in_r, in_w, in_b;
      in_r = !wr && ar_done && !r_fin;
      in_w = wr && aw_done && !w_fin;
      in_b = wr && w_fin && !b_done;
      arready  = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      awready  = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      rvalid   = in_r && (mode != 1 || $urandom_range(0, 2) != 0);
      rdata    = rvalid ? rdat_tab[rb] : $urandom;
      rresp    = rvalid ? rresp_tab[rb] : 2'b00;
      rlast    = rvalid ? rlast_tab[rb] : 1'b0;
      rd_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      if (mode == 3 && rb == 2 && hold < 10) begin
        rd_ready = 1'b0;
        hold++;
      end
      wd_valid = (wb < n_beats) && (mode != 1 || $urandom_range(0, 2) != 0);
      wd_data  = (wb < n_beats) ? wdat_tab[wb] : 32'h0;
      wd_strb  = (wb < n_beats) ? wstrb_tab[wb] : 4'h0;
      wready   = (mode == 2) ? cyc[0] : (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      bvalid   = in_b && (mode != 1 || $urandom_range(0, 1) != 0);
      bresp    = bresp_val;
      #1;
      if (abort_at >= 0 && rb == abort_at) begin
        rst_n = 1'b0;
        #1;
        check_eq("reset_outs", 64'({arvalid, awvalid, rready, rd_valid, wvalid, wd_ready,
                                    bready, done, cmd_ready, done_err}), 64'd0);
        idle_inputs();
        repeat (3) begin
          @(negedge clk);
          check_eq("reset_no_done", 64'({done, cmd_ready, arvalid}), 64'd0);
        end
        rst_n = 1'b1;
        return;
      end
      check_eq("cmd_ready_busy", 64'(cmd_ready), 64'd0);
      check_eq("done", 64'(done), 64'(done_due));
      if (done_due) begin
        check_eq("done_err", 64'(done_err), 64'(exp_err));
        done_cyc = cyc;
      end
      done_due = 0;
      check_eq("arvalid", 64'(arvalid), 64'(!wr && !ar_done));
      check_eq("awvalid", 64'(awvalid), 64'(wr && !aw_done));
      if (arvalid)
        check_eq("ar_chan", 64'({araddr, arlen, arsize, arburst, arcache, arprot}),
                 64'({addr, 4'd0, len, 3'd2, 2'b01, 4'd0, 3'd0}));
      if (awvalid)
        check_eq("aw_chan", 64'({awaddr, awlen, awsize, awburst, awcache, awprot}),
                 64'({addr, 4'd0, len, 3'd2, 2'b01, 4'd0, 3'd0}));
      check_eq("rready", 64'(rready), 64'(in_r && rd_ready));
      check_eq("rd_valid", 64'(rd_valid), 64'(in_r && rvalid));
      check_eq("wvalid", 64'(wvalid), 64'(in_w && wd_valid));
      check_eq("wd_ready", 64'(wd_ready), 64'(in_w && wready));
      check_eq("bready", 64'(bready), 64'(in_b));
      if (!wr && !ar_done && arready) ar_done = 1;
      if (wr && !aw_done && awready) aw_done = 1;
      if (in_r && rvalid && rd_ready) begin
        check_eq("rd_beat", 64'({rd_data, rd_last}), 64'({rdat_tab[rb], rb == int'(len)}));
        if (rb == int'(len)) begin
          r_fin = 1;
          done_due = 1;
        end
        rb++;
      end
      if (in_w && wd_valid && wready) begin
        check_eq("w_beat", 64'({wdata, wstrb, wlast}),
                 64'({wdat_tab[wb], wstrb_tab[wb], wb == int'(len)}));
        if (wb == int'(len)) w_fin = 1;
        wb++;
      end
      if (in_b && bvalid) begin
        b_done = 1;
        done_due = 1;
      end
      @(negedge clk);
      cyc++;
    end
    if (done_cyc < 0) check_eq("timeout", 64'd1, 64'd0);
    idle_inputs();
    #1 check_eq("cmd_ready_after", 64'({cmd_ready, done}), 64'b10);
  endtask

  initial begin
    int dc;
    idle_inputs();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("reset_state", 64'({cmd_ready, arvalid, awvalid, rready, wvalid, bready,
                                 done, done_err}), 64'd0);
    rst_n = 1'b1;

    // Zero-wait 4-beat read returning 0..3.
    set_clean(4'd3);
    for (int i = 0; i < 4; i++) rdat_tab[i] = i;
    run_txn(1'b0, 32'h1000, 4'd3, 0, -1, dc);
    check_eq("rd_len3_lat", 64'(dc), 64'd6);

    set_clean(4'd0);
    run_txn(1'b0, 32'h40, 4'd0, 0, -1, dc);
    check_eq("rd_len0_lat", 64'(dc), 64'd3);

    set_clean(4'd0);
    run_txn(1'b1, 32'h80, 4'd0, 0, -1, dc);
    check_eq("wr_len0_lat", 64'(dc), 64'd4);

    // Two-beat write with wready toggling.
    set_clean(4'd1);
    wdat_tab[0] = 32'hA5A5A5A5; wdat_tab[1] = 32'h5A5A5A5A;
    wstrb_tab[0] = 4'hF; wstrb_tab[1] = 4'hF;
    run_txn(1'b1, 32'h2000, 4'd1, 2, -1, dc);

    set_clean(4'd0);
    rresp_tab[0] = 2'b10;
    run_txn(1'b0, 32'h3000, 4'd0, 0, -1, dc);

    set_clean(4'd2);
    bresp_val = 2'b11;
    run_txn(1'b1, 32'h3100, 4'd2, 0, -1, dc);

    set_clean(4'd2);
    rlast_tab[1] = 1'b1;
    run_txn(1'b0, 32'h3200, 4'd2, 0, -1, dc);

    // Reset in the middle of a 16-beat read, then a clean 16-beat read.
    set_clean(4'd15);
    run_txn(1'b0, 32'h4000, 4'd15, 0, 5, dc);
    set_clean(4'd15);
    run_txn(1'b0, 32'h4000, 4'd15, 0, -1, dc);
    check_eq("rd_len15_lat", 64'(dc), 64'd18);

    set_clean(4'd7);
    run_txn(1'b0, 32'h5000, 4'd7, 3, -1, dc);

    for (int t = 0; t < 40; t++) begin
      logic [3:0] len;
      bit wr;
      len = 4'($urandom);
      wr  = 1'($urandom);
      set_clean(len);
      for (int i = 0; i < 16; i++)
        if ($urandom_range(0, 9) == 0) rresp_tab[i] = 2'($urandom_range(1, 3));
      if ($urandom_range(0, 5) == 0) begin
        int k = $urandom_range(0, int'(len));
        rlast_tab[k] = !rlast_tab[k];
      end
      if ($urandom_range(0, 4) == 0) bresp_val = 2'($urandom_range(1, 3));
      run_txn(wr, $urandom & 32'hFFFF_FFFC, len, 1, -1, dc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
